ddr2_cmd_arbiter: RTL
=====================

// Module: ddr2_cmd_arbiter
// PURPOSE
//   Owns the DDR2 command/address bus. Sequences power-up init, then shares the bus among
//   the auto-refresh, write and read engines. Refresh has top priority. Read/write is
//   direction-sticky, with a streak limit that prevents starvation.
//   Sits between the per-function engines and the DDR2 pad outputs.
// PARAMETERS
//   BA_BITS        3     bank address width
//   ADDR_BITS      13    row/column address width
//   RW_STREAK_MAX  8     max consecutive same-direction grants while the other direction waits
//   OP_TIMEOUT     1024  cycles an engine may hold the bus before a forced abort
// PORTS
//   ck         in   1          system clock; all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   init_end   in   1          init engine done (level; stays high once set)
//   init_cmd   in   4          {cs_n,ras_n,cas_n,we_n} from the init engine
//   init_ba    in   BA_BITS    init bank address
//   init_addr  in   ADDR_BITS  init address
//   aref_req   in   1          refresh request (level; held until aref_en)
//   aref_cmd   in   4          refresh engine command
//   aref_addr  in   ADDR_BITS  refresh engine address (ba driven 0)
//   aref_end   in   1          refresh sequence done (1-cycle pulse)
//   wr_req/rd_req                 in  1          write/read request (level; held until its _en)
//   wr_cmd/rd_cmd                 in  4          engine command
//   wr_ba/rd_ba                   in  BA_BITS    engine bank
//   wr_addr/rd_addr               in  ADDR_BITS  engine address
//   wr_end/rd_end                 in  1          engine done (1-cycle pulse)
//   aref_en/wr_en/rd_en  out  1          1-cycle grant pulse to the engine
//   cmd_out    out  4          registered {cs_n,ras_n,cas_n,we_n} to the pads
//   ba_out     out  BA_BITS    registered bank address
//   addr_out   out  ADDR_BITS  registered address
//   busy       out  1          high in any state except IDLE
//   timeout    out  1          1-cycle pulse on a forced abort
// BEHAVIOUR
//   States (one-hot, 5 bit): INIT, IDLE, AREF, WRITE, READ.
//   Reset state: INIT; all _en = 0; timeout = 0; cmd_out = 4'b0111 (NOP); ba/addr_out = 0;
//     streak = 0; last_dir = READ; busy = 1.
//   Reset is honoured in any state and aborts any operation. After reset, leave INIT only
//     when init_end is seen again.
//   INIT: mux the init_* inputs onto the outputs. When init_end = 1, go to IDLE.
//   IDLE: cmd_out = NOP, ba/addr_out = 0. Grant priority:
//     1. aref_req -> AREF.
//     2. Only one of wr_req/rd_req -> that direction.
//     3. Both pending -> last_dir, unless streak >= RW_STREAK_MAX; then the other direction.
//   Grant: next state and its _en pulse are registered on the same edge. So _en is high
//     in the first cycle of AREF/WRITE/READ and low afterwards.
//   Streak counter:
//     - Saturating, width clog2(RW_STREAK_MAX+1).
//     - On a W/R grant: +1 if same as last_dir, else set to 1; last_dir updated.
//     - An AREF grant leaves streak and last_dir unchanged.
//   AREF/WRITE/READ: outputs = registered copy of the owning engine's cmd/ba/addr, 1-cycle
//     latency. Inputs from non-owning engines are ignored.
//   Owner's _end: return to IDLE on the next edge. The command present on the _end cycle
//     is still forwarded. Cycle after that: NOP.
//   Minimum one IDLE cycle between any two operations; no back-to-back grants.
//   aref_req during WRITE/READ never preempts; it is served at the next IDLE decision.
//   _end pulses from non-owners and _end pulses in IDLE are ignored.
//   Timeout counter:
//     - Clears on every grant; counts cycles in AREF/WRITE/READ.
//     - Reaching OP_TIMEOUT-1 without _end: go to IDLE, pulse timeout, cmd_out = NOP.
//     - streak is unchanged.
//   Simultaneous _end and timeout: _end wins, no timeout pulse.
// TESTING
//   Reset, then init_end high at cycle 20 -> state IDLE at 21; cmd_out = 4'b0111 and busy = 0
//     at 22.
//   wr_req and aref_req high together in IDLE -> aref_en pulses once. wr_en follows only
//     after aref_end, plus 1 IDLE cycle.
//   wr_req and rd_req held high, RW_STREAK_MAX = 8 (last_dir = READ after reset) ->
//     grant order R×8, W×8, R×8.
//   In WRITE, wr_cmd = 4'b0100, wr_ba = 3, wr_addr = 13'h0A5 -> outputs show these values
//     1 cycle later. rd_* changes have no effect.
//   WRITE with no wr_end, OP_TIMEOUT = 16 -> timeout pulses at cycle 16 after the grant;
//     state IDLE; cmd_out NOP.
//   rst asserted mid-READ -> next cycle: INIT, outputs NOP/0, rd_en = 0.

Source files
------------

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter
// Owns the DDR2 command/address bus. Sequences power-up init, then shares the
// bus among the auto-refresh, write and read engines. Refresh always wins an
// IDLE decision. Read/write grants stick to the last direction until a streak
// limit is reached while the other direction is also waiting. An engine that
// holds the bus too long is aborted. All pad outputs are registered.
module ddr2_cmd_arbiter #(
    parameter int BA_BITS       = 3,
    parameter int ADDR_BITS     = 13,
    parameter int RW_STREAK_MAX = 8,
    parameter int OP_TIMEOUT    = 1024
) (
    input  logic                 ck,
    input  logic                 rst,
    // init engine
    input  logic                 init_end,
    input  logic [3:0]           init_cmd,
    input  logic [BA_BITS-1:0]   init_ba,
    input  logic [ADDR_BITS-1:0] init_addr,
    // auto-refresh engine
    input  logic                 aref_req,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic                 aref_end,
    // write engine
    input  logic                 wr_req,
    input  logic [3:0]           wr_cmd,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 wr_end,
    // read engine
    input  logic                 rd_req,
    input  logic [3:0]           rd_cmd,
    input  logic [BA_BITS-1:0]   rd_ba,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic                 rd_end,
    // grants
    output logic                 aref_en,
    output logic                 wr_en,
    output logic                 rd_en,
    // pads
    output logic [3:0]           cmd_out,
    output logic [BA_BITS-1:0]   ba_out,
    output logic [ADDR_BITS-1:0] addr_out,
    // status
    output logic                 busy,
    output logic                 timeout
);

    localparam int STREAK_W = (RW_STREAK_MAX > 0) ? $clog2(RW_STREAK_MAX + 1) : 1;
    localparam int TCNT_W   = (OP_TIMEOUT > 1) ? $clog2(OP_TIMEOUT) : 1;

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(RW_STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_FULL  = {STREAK_W{1'b1}};
    localparam logic [TCNT_W-1:0]   TCNT_LAST    = TCNT_W'(OP_TIMEOUT - 1);

    // {cs_n,ras_n,cas_n,we_n} = NOP
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_IDLE  = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_t;

    state_t                 state;
    logic [STREAK_W-1:0]    streak;
    logic                   last_dir;
    logic [TCNT_W-1:0]      tcnt;

    logic                   streak_hit;
    logic                   grant_write;
    logic                   grant_read;

    logic                   own_end;
    logic [3:0]             own_cmd;
    logic [BA_BITS-1:0]     own_ba;
    logic [ADDR_BITS-1:0]   own_addr;

    // Streak value after granting direction dir: a direction change restarts
    // the run at one, a repeat extends it without wrapping.
    function automatic logic [STREAK_W-1:0] streak_after(
        input logic                dir,
        input logic                cur_dir,
        input logic [STREAK_W-1:0] cur
    );
        if (dir != cur_dir) begin
            return STREAK_W'(1);
        end
        if (cur == STREAK_FULL) begin
            return cur;
        end
        return cur + STREAK_W'(1);
    endfunction

    // Read/write choice for an IDLE decision: a lone requester wins; when both
    // wait, stay on last_dir until the streak limit flips the choice.
    always_comb begin
        streak_hit  = (streak >= STREAK_LIMIT);
        grant_write = wr_req && (!rd_req || ((last_dir == DIR_WRITE) ^ streak_hit));
        grant_read  = rd_req && !grant_write;
    end

    // Select the engine that currently owns the bus; non-owners are invisible.
    always_comb begin
        own_end  = 1'b0;
        own_cmd  = CMD_NOP;
        own_ba   = '0;
        own_addr = '0;
        case (state)
            ST_AREF: begin
                own_end  = aref_end;
                own_cmd  = aref_cmd;
                own_addr = aref_addr;
            end
            ST_WRITE: begin
                own_end  = wr_end;
                own_cmd  = wr_cmd;
                own_ba   = wr_ba;
                own_addr = wr_addr;
            end
            ST_READ: begin
                own_end  = rd_end;
                own_cmd  = rd_cmd;
                own_ba   = rd_ba;
                own_addr = rd_addr;
            end
            default: begin
                own_end  = 1'b0;
            end
        endcase
    end

    // Arbiter FSM with registered grants, pad outputs, streak and timeout state.
    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= ST_INIT;
            aref_en  <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            timeout  <= 1'b0;
            cmd_out  <= CMD_NOP;
            ba_out   <= '0;
            addr_out <= '0;
            busy     <= 1'b1;
            streak   <= '0;
            last_dir <= DIR_READ;
            tcnt     <= '0;
        end else begin
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_INIT: begin
                    cmd_out  <= init_cmd;
                    ba_out   <= init_ba;
                    addr_out <= init_addr;
                    if (init_end) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    cmd_out  <= CMD_NOP;
                    ba_out   <= '0;
                    addr_out <= '0;
                    tcnt     <= '0;
                    if (aref_req) begin
                        // refresh leaves the read/write history untouched
                        state   <= ST_AREF;
                        aref_en <= 1'b1;
                        busy    <= 1'b1;
                    end else if (grant_write) begin
                        state    <= ST_WRITE;
                        wr_en    <= 1'b1;
                        busy     <= 1'b1;
                        streak   <= streak_after(DIR_WRITE, last_dir, streak);
                        last_dir <= DIR_WRITE;
                    end else if (grant_read) begin
                        state    <= ST_READ;
                        rd_en    <= 1'b1;
                        busy     <= 1'b1;
                        streak   <= streak_after(DIR_READ, last_dir, streak);
                        last_dir <= DIR_READ;
                    end
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    if (own_end) begin
                        // the command on the _end cycle still reaches the pads
                        cmd_out  <= own_cmd;
                        ba_out   <= own_ba;
                        addr_out <= own_addr;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else if (tcnt == TCNT_LAST) begin
                        cmd_out  <= CMD_NOP;
                        ba_out   <= '0;
                        addr_out <= '0;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                    end else begin
                        cmd_out  <= own_cmd;
                        ba_out   <= own_ba;
                        addr_out <= own_addr;
                        tcnt     <= tcnt + TCNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    cmd_out  <= CMD_NOP;
                    ba_out   <= '0;
                    addr_out <= '0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule
